// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of Fmeas over 2^(Gsel+4) Clk cycles.
// Optional FREQ_METER_CONTINUOUS_EN: back-to-back gates while Start is held high.
module freq_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Fmeas,
  input  logic             Start,
  input  logic [3:0]       Gsel,
  output logic [CNT_W-1:0] Count,
  output logic             Valid,
  output logic             Busy,
  output logic             Overflow
);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

  localparam int              SW      = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0]   SET_END = SW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [3:0]             gsel_q, gsel_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic [19:0]            gate_q, gate_d, gate_last;
  logic [CNT_W-1:0]       ecnt_q, ecnt_d, ecnt_inc;
  logic                   sat_q, sat_d, sat_inc;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det, settle_done, gate_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      gsel_q   <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      ecnt_q   <= '0;
      sat_q    <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      gsel_q   <= gsel_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      ecnt_q   <= ecnt_d;
      sat_q    <= sat_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gate_last   = (20'd1 << ({1'b0, gsel_q} + 5'd4)) - 20'd1;
  assign settle_done = (settle_q == SET_END);
  assign gate_done   = (state_q == GATE) && (gate_q == gate_last);

  // Next-state logic; Gsel is only captured when a gate is about to be armed.
  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = SETTLE;
        gsel_d  = Gsel;
      end
      SETTLE: if (settle_done) state_d = GATE;
      GATE:   if (gate_done)   state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (Start) begin
          gsel_d = Gsel;
`ifdef FREQ_METER_CONTINUOUS_EN
          state_d = GATE;
`else
          state_d = SETTLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters sit at zero outside GATE, which gives the clear-on-entry behaviour.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], Fmeas};
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    ecnt_inc = (edge_det && (ecnt_q != CNT_MAX)) ? ecnt_q + CNT_W'(1) : ecnt_q;
    sat_inc  = sat_q | (edge_det && (ecnt_q == CNT_MAX));
    settle_d = (state_q == SETTLE) ? settle_q + SW'(1) : '0;
    gate_d   = (state_q == GATE) ? gate_q + 20'd1 : '0;
    ecnt_d   = (state_q == GATE) ? ecnt_inc : '0;
    sat_d    = (state_q == GATE) ? sat_inc : 1'b0;
    count_d  = count_q;
    ovf_d    = ovf_q;
    // The final GATE cycle's edge is folded in so it still counts.
    if (gate_done) begin
      count_d = ecnt_inc;
      ovf_d   = sat_inc;
    end
  end

  always_comb begin
    Valid    = (state_q == DONE);
`ifdef FREQ_METER_CONTINUOUS_EN
    Busy     = (state_q == SETTLE) || (state_q == GATE) || ((state_q == DONE) && Start);
`else
    Busy     = (state_q == SETTLE) || (state_q == GATE);
`endif
    Count    = count_q;
    Overflow = ovf_q;
  end

endmodule
